// File: rtl/alu_console_pkg.sv
// alu_console_pkg: opcodes, flag bit positions and the hex glyph table
package alu_console_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } op_e;

    localparam int ZF = 3;
    localparam int CF = 2;
    localparam int OF = 1;
    localparam int SF = 0;

    // Active-low {dp,g,f,e,d,c,b,a}, glyph for nibble n lives at bits [8n+7:8n]
    localparam logic [127:0] GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex7(input logic [3:0] n);
        return GLYPHS[n*8 +: 8];
    endfunction

endpackage

// File: rtl/alu_console_seg_scan.sv
// seg_scan: time-multiplexed hex display driver with registered glyph output
module seg_scan
    import alu_console_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int SCAN_DIV = 50000,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW = $clog2(SCAN_DIV)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    output logic [7:0]            seg,
    output logic [DW-1:0]         which
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] which_q, which_d;
    logic [7:0]    seg_q, seg_d;
    logic          wrap;

    // Dwell counter advances the digit; glyph is looked up for the digit selected after this edge
    always_comb begin
        wrap    = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        which_d = !wrap ? which_q : (which_q == DW'(DIGITS - 1)) ? '0 : which_q + DW'(1);
        seg_d   = hex7(value[{which_d, 2'b00} +: 4]);
    end

    // Scan state and glyph register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            which_q <= '0;
            seg_q   <= 8'hC0;
        end else begin
            cnt_q   <= cnt_d;
            which_q <= which_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign which = which_q;

endmodule

// File: rtl/alu_console.sv
// alu_console: button-strobed ALU with registered result/flags and hex display
module alu_console
    import alu_console_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SCAN_DIV = 50000,
    localparam int DIGITS = WIDTH / 4,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_f,
    output logic [3:0]       FR,
    output logic [7:0]       seg,
    output logic [DW-1:0]    which
);

    localparam int SHW = $clog2(WIDTH);

    logic [2:0]       sa_q, sa_d, sb_q, sb_d, sf_q, sf_d;
    logic             stb_a, stb_b, stb_f;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d, res;
    logic [3:0]       op_q, op_d, fr_q, fr_d, fr_c;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic             of_add, of_sub;

    // Two-stage synchronisers plus a third stage for rising-edge detection; strobes update the registers
    always_comb begin
        sa_d  = {sa_q[1:0], ld_a};
        sb_d  = {sb_q[1:0], ld_b};
        sf_d  = {sf_q[1:0], ld_f};
        stb_a = sa_q[1] & ~sa_q[2];
        stb_b = sb_q[1] & ~sb_q[2];
        stb_f = sf_q[1] & ~sf_q[2];
        a_d   = stb_a ? sw : a_q;
        b_d   = stb_b ? sw : b_q;
        op_d  = stb_f ? sw[3:0] : op_q;
        f_d   = stb_f ? res : f_q;
        fr_d  = stb_f ? fr_c : fr_q;
    end

    // ALU on the pre-edge operands; reserved opcodes fall out as F=0 giving flags 1000
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        shamt  = b_q[SHW-1:0];
        of_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        of_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
        res    = '0;
        case (op_d)
            OP_ADD:  res = sum[WIDTH-1:0];
            OP_SUB:  res = diff[WIDTH-1:0];
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOR:  res = ~(a_q | b_q);
            OP_SLL:  res = a_q << shamt;
            OP_SRL:  res = a_q >> shamt;
            OP_SRA:  res = $signed(a_q) >>> shamt;
            OP_SLT:  res = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: res = WIDTH'(a_q < b_q);
            default: res = '0;
        endcase
        fr_c     = '0;
        fr_c[ZF] = res == '0;
        fr_c[SF] = res[WIDTH-1];
        fr_c[CF] = (op_d == OP_ADD) ? sum[WIDTH] : (op_d == OP_SUB) ? diff[WIDTH] : 1'b0;
        fr_c[OF] = (op_d == OP_ADD) ? of_add : (op_d == OP_SUB) ? of_sub : 1'b0;
    end

    // Synchroniser chains, operands, opcode, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= '0;
            sb_q <= '0;
            sf_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            f_q  <= '0;
            fr_q <= '0;
        end else begin
            sa_q <= sa_d;
            sb_q <= sb_d;
            sf_q <= sf_d;
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
            f_q  <= f_d;
            fr_q <= fr_d;
        end
    end

    assign FR = fr_q;

    // Fed the next-state result so the glyph is valid on the same edge F updates
    seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .value (f_d),
        .seg   (seg),
        .which (which)
    );

endmodule

// File: tb/tb_alu_console.sv
// tb_alu_console: randomized and directed checks against a behavioural ALU console model
module tb_alu_console;

    localparam int SD = 4;

    logic        clk = 0, rst_n = 1, ld_a = 0, ld_b = 0, ld_f = 0;
    logic [31:0] sw = 0;
    logic [3:0]  FR;
    logic [7:0]  seg;
    logic [2:0]  which;

    int checks = 0, errors = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    alu_console #(.WIDTH(32), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f),
        .FR(FR), .seg(seg), .which(which)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Returns {ZF,CF,OF,SF,F} from plain integer arithmetic
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int ia, ib;
        longint s, u;
        logic [31:0] f;
        logic cf, of;
        ia = a;
        ib = b;
        cf = 0;
        of = 0;
        case (op)
            0: begin
                f = a + b;
                u = longint'(a) + longint'(b);
                s = longint'(ia) + longint'(ib);
                cf = (u >> 32) != 0;
                of = s != longint'(int'(s));
            end
            1: begin
                f = a - b;
                s = longint'(ia) - longint'(ib);
                cf = a < b;
                of = s != longint'(int'(s));
            end
            2: f = a & b;
            3: f = a | b;
            4: f = a ^ b;
            5: f = ~(a | b);
            6: f = a << b[4:0];
            7: f = a >> b[4:0];
            8: f = ia >>> b[4:0];
            9: f = (ia < ib) ? 1 : 0;
            10: f = (a < b) ? 1 : 0;
            default: f = 0;
        endcase
        return {f == 0, cf, of, f[31], f};
    endfunction

    // Model: a button acts on the edge where its level two samples back is high and three back is low
    logic [31:0] m_a, m_b, m_f;
    logic [3:0]  m_fr;
    logic [2:0]  ha, hb, hf;
    int          m_cnt, m_which;

    always @(posedge clk or negedge rst_n) begin
        logic [35:0] r;
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_f <= 0; m_fr <= 0;
            ha <= 0; hb <= 0; hf <= 0;
            m_cnt <= 0; m_which <= 0;
        end else begin
            r = alu_ref(sw[3:0], m_a, m_b);
            if (hf[1] && !hf[2]) begin
                m_f  <= r[31:0];
                m_fr <= r[35:32];
            end
            if (ha[1] && !ha[2]) m_a <= sw;
            if (hb[1] && !hb[2]) m_b <= sw;
            ha <= {ha[1:0], ld_a};
            hb <= {hb[1:0], ld_b};
            hf <= {hf[1:0], ld_f};
            m_cnt <= (m_cnt + 1) % SD;
            if (m_cnt == SD - 1) m_which <= (m_which + 1) % 8;
        end
    end

    // Every cycle: flags, digit index and the glyph of the model's result at that digit
    always @(negedge clk) begin
        check("FR", {28'b0, FR}, {28'b0, m_fr});
        check("which", {29'b0, which}, m_which);
        check("seg", {24'b0, seg}, {24'b0, glyph[m_f[m_which*4 +: 4]]});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic a, input logic b, input logic f, input logic [31:0] v);
        @(negedge clk);
        sw = v; ld_a = a; ld_b = b; ld_f = f;
        tick(5);
        ld_a = 0; ld_b = 0; ld_f = 0;
        tick(5);
    endtask

    // Pins the model to hand-computed values and reads every displayed digit back
    task automatic expect_f(input string name, input logic [31:0] f, input logic [3:0] fr);
        logic [7:0] got [8];
        check({name, " model F"}, m_f, f);
        check({name, " model FR"}, {28'b0, m_fr}, {28'b0, fr});
        check({name, " FR"}, {28'b0, FR}, {28'b0, fr});
        repeat (8 * SD + 2) begin
            @(negedge clk);
            got[which] = seg;
        end
        for (int d = 0; d < 8; d++) check({name, " digit"}, {24'b0, got[d]}, {24'b0, glyph[f[d*4 +: 4]]});
    endtask

    task automatic op3(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        press(1, 0, 0, a);
        press(0, 1, 0, b);
        press(0, 0, 1, {28'b0, op});
    endtask

    initial begin
        logic [2:0] p;
        int t;
        #1 rst_n = 0;
        tick(3);
        rst_n = 1;
        tick(2);
        expect_f("reset", 32'h0, 4'b0000);
        op3(5, 3, 0);
        expect_f("add5_3", 32'h8, 4'b0000);
        op3(1, 0, 4);
        expect_f("xor", 32'h1, 4'b0000);
        op3(3, 5, 1);
        expect_f("sub", 32'hFFFFFFFE, 4'b0101);
        op3(32'h7FFFFFFF, 1, 0);
        expect_f("add_ovf", 32'h80000000, 4'b0011);
        op3(32'hFFFFFFFF, 1, 0);
        expect_f("add_carry", 32'h0, 4'b1100);
        press(1, 0, 0, 5);
        press(0, 1, 0, 3);
        press(1, 0, 1, 2);
        expect_f("simul", 32'h1, 4'b0000);
        press(0, 0, 1, 0);
        expect_f("new_a", 32'h5, 4'b0000);
        @(negedge clk);
        sw = 6; ld_f = 1;
        tick(10);
        sw = 9; ld_a = 1;
        tick(5);
        ld_a = 0;
        tick(85);
        ld_f = 0;
        tick(5);
        expect_f("held", 32'h10, 4'b0000);
        press(0, 0, 1, 12);
        expect_f("reserved", 32'h0, 4'b1000);
        op3(32'hFFFFFFFF, 1, 9);
        expect_f("slt", 32'h1, 4'b0000);
        press(0, 0, 1, 10);
        expect_f("sltu", 32'h0, 4'b1000);
        op3(32'h80000000, 4, 8);
        expect_f("sra", 32'hF8000000, 4'b0001);
        p = which;
        @(negedge clk);
        t = 0;
        while (!(p == 7 && which == 0) && t < 100) begin
            p = which;
            @(negedge clk);
            t++;
        end
        check("scan wrap seen", {31'b0, t < 100}, 1);
        for (int i = 1; i < 36; i++) begin
            @(negedge clk);
            check("scan seq", {29'b0, which}, (i / SD) % 8);
        end
        tick(2);
        #2 rst_n = 0;
        #1;
        check("rst which", {29'b0, which}, 0);
        check("rst seg", {24'b0, seg}, 32'hC0);
        check("rst FR", {28'b0, FR}, 0);
        sw = 32'h77; ld_a = 1;
        tick(3);
        rst_n = 1;
        tick(10);
        press(0, 1, 0, 1);
        ld_a = 0;
        press(0, 0, 1, 0);
        expect_f("held_thru_rst", 32'h78, 4'b0000);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: sw = 32'h0;
                    1: sw = 32'hFFFFFFFF;
                    2: sw = 32'h80000000;
                    3: sw = 32'h7FFFFFFF;
                    default: sw = $urandom;
                endcase
            end
            if ($urandom_range(0, 5) == 0) ld_a = ~ld_a;
            if ($urandom_range(0, 5) == 0) ld_b = ~ld_b;
            if ($urandom_range(0, 5) == 0) ld_f = ~ld_f;
        end
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_console.md
# alu_console

Parametrised successor to the multi-function ALU console: a single-clock ALU that latches operands A and B and an opcode from the switch bank on synchronised button strobes, registers the result F and a 4-bit flag word, and drives a time-multiplexed seven-segment display of F in hex. It sits between the board I/O (switches, buttons, display) and nothing else; it is the top-level lab block for the ALU exercise.

## Interface
- WIDTH, 32: operand/result width; multiple of 4, range 8..32.
- SCAN_DIV, 50000: clk cycles each digit stays lit; ≥ 2.
- Derived: DIGITS = WIDTH/4; DW = max(1, clog2(DIGITS)).

- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  WIDTH  operand value (on ld_a/ld_b) or opcode in sw[3:0] (on ld_f).
- ld_a  in  1  button level, asynchronous; rising edge loads A.
- ld_b  in  1  button level, asynchronous; rising edge loads B.
- ld_f  in  1  button level, asynchronous; rising edge executes and stores F/FR.
- FR  out  4  flags {ZF, CF, OF, SF} (bit 3 down to 0).
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- which  out  DW  index of the digit currently driven (0 = least-significant nibble).

## Operation
- Each ld_* passes through a 2-FF synchroniser and a rising-edge detector; the resulting one-cycle pulse is the strobe. Levels held high produce one strobe only.
- Strobe A: A <= sw. Strobe B: B <= sw. Strobe F: op <= sw[3:0]; F and FR computed from the A/B values registered before this edge.
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA (shift amount B[clog2(WIDTH)−1:0]), 9 SLT (signed, F = 0/1), 10 SLTU (unsigned); 11..15 reserved → F = 0, FR = 4'b1000.
- Flags: ZF = (F == 0); SF = F[WIDTH−1]; CF = carry-out for ADD, borrow (A < B unsigned) for SUB, else 0; OF = two's-complement overflow for ADD/SUB, else 0.
- Simultaneous strobes: A and B load on the same edge as F executes; F uses pre-edge A/B.
- Display: scan counter counts 0..SCAN_DIV−1; at wrap, which advances, DIGITS−1 wraps to 0. seg = hex glyph of F[4·which+3 : 4·which], dp always off (bit 7 = 1). Glyphs standard 0–9, A, b, C, d, E, F.

## Timing
- Button edge to strobe: 3 clk (2 sync + 1 edge reg). Strobe F to F/FR/seg valid: 1 clk (registered on strobe edge).
- which/seg update on the same edge; seg is registered, glitch-free.
- Reset (any time, including mid-scan or with buttons held): A, B, F, op = 0; FR = 4'b0000; which = 0; scan counter = 0; synchroniser/edge regs = 0; seg = 8'hC0 (“0”). A button held high through reset release produces one strobe after release.

## Structure
- alu_console_pkg: opcode constants/enum, flag bit indices (ZF=3, CF=2, OF=1, SF=0), function hex7(nibble) → active-low 8-bit glyph.
- Sub-module seg_scan (params DIGITS, SCAN_DIV; inputs value, clk, rst_n; outputs seg, which). ALU datapath and strobe logic stay in alu_console.

## Test plan
Bench uses SCAN_DIV = 4, WIDTH = 32.
- Reset, sw=5 ld_a, sw=3 ld_b, sw=0 ld_f → F=8, FR=4'b0000; with which=0, seg=8'h80; other digits 8'hC0.
- sw=1 ld_a, sw=0 ld_b, sw=4 ld_f → F=1 (XOR), FR=0000, digit0 seg=8'hF9.
- A=3, B=5, op 1 → F=32'hFFFFFFFE, FR=4'b0101 (CF, SF); A=7FFFFFFF, B=1, op 0 → F=32'h80000000, FR=4'b0011 (OF, SF); A=FFFFFFFF, B=1, op 0 → F=0, FR=4'b1100.
- ld_a and ld_f rising same cycle with sw=2 (A was 5, B=3) → F=(5 AND 3)=1, op=2, A=2 afterwards; ld_f held high 100 clk → exactly one execution.
- Scan check: which cycles 0..7 every 4 clk, wraps to 0; assert rst_n low mid-scan → which=0, seg=8'hC0, FR=0 immediately; resumes scanning after release.
